// File: rtl/uart_tx_feeder_if.sv
// Producer and UART-side signals of the transmit feeder, bundled for port connection.
// The slave modport is the feeder itself; the master modport is the surrounding logic.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          flush;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          ack_timeout;

    modport master (
        output wr_valid, wr_data, flush, tx_busy,
        input  wr_ready, tx_start, tx_data, level, empty, full, overflow, ack_timeout
    );

    modport slave (
        input  wr_valid, wr_data, flush, tx_busy,
        output wr_ready, tx_start, tx_data, level, empty, full, overflow, ack_timeout
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus a sequencer that holds tx_start until the UART acknowledges with tx_busy,
// dropping the byte if no acknowledge arrives within ACK_TIMEOUT cycles.
module uart_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_feeder_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, full_q, wr_ready_q, overflow_q;

    state_e        state_q;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic          ack_timeout_q;
    logic [TW-1:0] timer_q;

    logic          wr_en_s;
    logic          pop_en_s;

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    assign wr_en_s  = bus.wr_valid && wr_ready_q && !bus.flush;
    assign pop_en_s = (state_q == ST_IDLE) && !empty_q && !bus.tx_busy && !bus.flush;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_en_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, pop_en_s})
                2'b10:   level_d = level_q + LW'(1'b1);
                2'b01:   level_d = level_q - LW'(1'b1);
                default: level_d = level_q;
            endcase
        end
    end

    // Byte storage; contents need no reset because level guards every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // FIFO bookkeeping with status flags registered from the next level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= (level_d == {LW{1'b0}});
            full_q     <= (level_d == LVL_FULL);
            wr_ready_q <= (level_d != LVL_FULL);
            overflow_q <= bus.wr_valid && full_q;
        end
    end

    // Transmit sequencer: tx_start is a level held until the UART raises tx_busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            ack_timeout_q <= 1'b0;
            timer_q       <= {TW{1'b0}};
        end else begin
            ack_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_en_s) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_start_q <= 1'b1;
                        timer_q    <= {TW{1'b0}};
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_q != TMR_MAX) begin
                        timer_q <= timer_q + TW'(1'b1);
                    end
                    // An acknowledge in the timeout cycle still wins.
                    if (bus.tx_busy) begin
                        tx_start_q <= 1'b0;
                        state_q    <= ST_BUSY;
                    end else if (timer_q == TMR_LAST) begin
                        tx_start_q    <= 1'b0;
                        ack_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!bus.tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready    = wr_ready_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.level       = level_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.overflow    = overflow_q;
    assign bus.ack_timeout = ack_timeout_q;
endmodule
